// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_out_t;

endpackage

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - valid/ready pipeline output register with flush
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_INSTR = NOP_INSTR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  fetch_out_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output fetch_out_t out_data
);

    logic       valid_q;
    fetch_out_t data_q;

    // A new word may enter when the register is empty or being drained this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Flush drops the held word regardless of out_ready; data is left stale since valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '{instr: RESET_INSTR, pc: '0};
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC/state fetch stage feeding decode; FETCH_PERF_EN adds fetch_count
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET  = 64'h0,
    parameter int unsigned     IMEM_SIZE = 10,
    parameter logic [ILEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fetch_valid;
    logic            fetch_ready;
    logic            flush;
    logic            in_range;
    fetch_out_t      fetch_word;
    fetch_out_t      out_word;
    logic [1:0]      unused_redirect_lsbs;

    // Targets are word aligned; the byte offset of a redirect is discarded.
    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign imem_addr  = pc_q >> 2;
    assign in_range   = imem_addr < 64'(IMEM_SIZE);
    assign fetch_word = '{instr: imem_data, pc: pc_q};
    assign halted     = halted_q;

    // Next PC / state: redirect beats everything, otherwise fetch in range or halt past the end.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        halted_d    = halted_q;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            state_d  = FETCH;
            halted_d = 1'b0;
            flush    = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    if (in_range) begin
                        fetch_valid = 1'b1;
                        if (fetch_ready) pc_d = pc_q + PC_STEP;
                    end else begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
                end
                HALT: begin
                    halted_d = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // PC, state and halt flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= PC_RESET;
            state_q  <= FETCH;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    fetch_out_reg #(
        .RESET_INSTR(NOP_INSTR)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (fetch_valid),
        .in_ready (fetch_ready),
        .in_data  (fetch_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_word)
    );

    assign out_instr = out_word.instr;
    assign out_pc    = out_word.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] count_q;

    // Count accepted handshakes, saturating; redirects do not clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_valid && out_ready && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule
